reg_stack: RTL and testbench

//   Shift-register operand stack for the stack-processor datapath: TOP (a) and NEXT (b) feed the ALU.
//   The ALU result returns on w. One stack operation executes per clock.

---
 rtl/reg_stack_pkg.sv | 16 +
 rtl/reg_stack_if.sv | 17 +
 rtl/reg_stack_cell.sv | 36 +++
 rtl/reg_stack.sv | 71 +++++++
 tb/tb_reg_stack.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/reg_stack_pkg.sv
// Shared definitions for the operand stack: op encodings and default data width.
package reg_stack_pkg;

  localparam int STK_WIDTH = 16;
  localparam int STK_DEPTH = 8;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_PUSH    = 3'd1,
    OP_REPLACE = 3'd2,
    OP_POP     = 3'd3,
    OP_POP2    = 3'd4,
    OP_SWAP    = 3'd5
  } stack_op_t;

endpackage

// File: rtl/reg_stack_if.sv
// Operand-stack port bundle: op/write data in, TOP/NEXT and occupancy out.
interface reg_stack_if #(
  parameter int WIDTH = reg_stack_pkg::STK_WIDTH,
  parameter int DEPTH = reg_stack_pkg::STK_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
);
  logic [2:0]       stackOP;
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;

  modport master (output stackOP, w, input a, b, count, empty, full);
  modport slave  (input stackOP, w, output a, b, count, empty, full);
endinterface

// File: rtl/reg_stack_cell.sv
// One stack entry: register plus next-value mux over the neighbour sources.
module reg_stack_cell
  import reg_stack_pkg::*;
#(
  parameter int WIDTH = STK_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] push_d,
  input  logic [WIDTH-1:0] repl_d,
  input  logic [WIDTH-1:0] pop_d,
  input  logic [WIDTH-1:0] pop2_d,
  input  logic [WIDTH-1:0] swap_d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] nxt;

  // Codes 6/7 fall into default and hold, same as NOP.
  always_comb begin
    nxt = q;
    case (op)
      OP_PUSH:    nxt = push_d;
      OP_REPLACE: nxt = repl_d;
      OP_POP:     nxt = pop_d;
      OP_POP2:    nxt = pop2_d;
      OP_SWAP:    nxt = swap_d;
      default:    nxt = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q <= '0;
    else        q <= nxt;
  end
endmodule

// File: rtl/reg_stack.sv
// Shift-register operand stack: entry 0 is TOP (a), entry 1 is NEXT (b).
module reg_stack
  import reg_stack_pkg::*;
#(
  parameter int WIDTH = STK_WIDTH,
  parameter int DEPTH = STK_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic        CLK,
  input  logic        RST_N,
  reg_stack_if.slave  stk_bus
);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

  logic [DEPTH-1:0][WIDTH-1:0] stk;
  logic [DEPTH+1:0][WIDTH-1:0] ext;
  logic [CNT_W-1:0]            cnt, cnt_nxt;

  // Two zero entries below the bottom so POP/POP2 shift in zeros.
  assign ext = {{(2*WIDTH){1'b0}}, stk};

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [WIDTH-1:0] push_d, repl_d, swap_d;
    if (i == 0) begin : g_top
      assign push_d = stk_bus.w;
      assign repl_d = stk_bus.w;
      assign swap_d = stk[1];
    end else begin : g_deep
      assign push_d = stk[i-1];
      assign repl_d = ext[i+1];
      assign swap_d = (i == 1) ? stk[0] : stk[i];
    end

    reg_stack_cell #(.WIDTH(WIDTH)) u_cell (
      .clk    (CLK),
      .rst_n  (RST_N),
      .op     (stk_bus.stackOP),
      .push_d (push_d),
      .repl_d (repl_d),
      .pop_d  (ext[i+1]),
      .pop2_d (ext[i+2]),
      .swap_d (swap_d),
      .q      (stk[i])
    );
  end

  // REPLACE is a net pop of one, but never leaves the stack below one entry.
  always_comb begin
    cnt_nxt = cnt;
    case (stk_bus.stackOP)
      OP_PUSH:    cnt_nxt = (cnt == DEPTH_C) ? DEPTH_C : cnt + ONE;
      OP_REPLACE: cnt_nxt = (cnt >= TWO) ? cnt - ONE : ONE;
      OP_POP:     cnt_nxt = (cnt == '0) ? '0 : cnt - ONE;
      OP_POP2:    cnt_nxt = (cnt >= TWO) ? cnt - TWO : '0;
      default:    cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

  assign stk_bus.a     = stk[0];
  assign stk_bus.b     = stk[1];
  assign stk_bus.count = cnt;
  assign stk_bus.empty = (cnt == '0);
  assign stk_bus.full  = (cnt == DEPTH_C);
endmodule

// File: tb/tb_reg_stack.sv
// Directed plus randomized checks of reg_stack against a queue-based stack model.
module tb_reg_stack;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  reg_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  reg_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .stk_bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] mq[$];
  int mcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    mq.delete();
    for (int i = 0; i < DEPTH; i++) mq.push_back('0);
    mcnt = 0;
  endtask

  // Model keeps exactly DEPTH slots; anything shifted past the bottom is lost.
  task automatic mdl_apply(input logic [2:0] op, input logic [WIDTH-1:0] wv);
    logic [WIDTH-1:0] t;
    case (op)
      3'd1: begin
        mq.push_front(wv); void'(mq.pop_back());
        mcnt = (mcnt < DEPTH) ? mcnt + 1 : DEPTH;
      end
      3'd2: begin
        void'(mq.pop_front()); void'(mq.pop_front());
        mq.push_front(wv); mq.push_back('0);
        mcnt = (mcnt >= 2) ? mcnt - 1 : 1;
      end
      3'd3: begin
        void'(mq.pop_front()); mq.push_back('0);
        mcnt = (mcnt > 0) ? mcnt - 1 : 0;
      end
      3'd4: begin
        void'(mq.pop_front()); void'(mq.pop_front());
        mq.push_back('0); mq.push_back('0);
        mcnt = (mcnt >= 2) ? mcnt - 2 : 0;
      end
      3'd5: begin
        t = mq[0]; mq[0] = mq[1]; mq[1] = t;
      end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".a"},     32'(bus.a),     32'(mq[0]));
    chk({tag, ".b"},     32'(bus.b),     32'(mq[1]));
    chk({tag, ".count"}, 32'(bus.count), 32'(mcnt));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(mcnt == 0));
    chk({tag, ".full"},  32'(bus.full),  32'(mcnt == DEPTH));
  endtask

  task automatic step(input string tag, input logic [2:0] op, input logic [WIDTH-1:0] wv,
                      input logic rst);
    @(negedge CLK);
    bus.stackOP = op;
    bus.w       = wv;
    RST_N       = ~rst;
    @(posedge CLK);
    if (rst) mdl_reset();
    else     mdl_apply(op, wv);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [2:0] op;
    logic [WIDTH-1:0] wv;
    mdl_reset();
    RST_N = 1'b0;
    bus.stackOP = 3'd1;
    bus.w = 16'd5;

    // Reset wins over a PUSH held during it
    step("rst0", 3'd1, 16'd5, 1'b1);
    step("rst1", 3'd1, 16'd5, 1'b1);
    chk("rst.empty", 32'(bus.empty), 32'd1);

    for (int v = 1; v <= 4; v++) step("push", 3'd1, WIDTH'(v), 1'b0);
    chk("push4.a", 32'(bus.a), 32'd4);
    chk("push4.b", 32'(bus.b), 32'd3);

    step("rep_add", 3'd2, mq[1] + mq[0], 1'b0);
    chk("rep_add.a", 32'(bus.a), 32'd7);
    step("rep_sub", 3'd2, mq[1] - mq[0], 1'b0);
    chk("rep_sub.a", 32'(bus.a), 32'hFFFB);
    step("rep_add2", 3'd2, mq[1] + mq[0], 1'b0);
    chk("rep_add2.a", 32'(bus.a), 32'hFFFC);
    chk("rep_add2.count", 32'(bus.count), 32'd1);

    step("push7", 3'd1, 16'd7, 1'b0);
    step("swap", 3'd5, 16'd0, 1'b0);
    chk("swap.a", 32'(bus.a), 32'hFFFC);
    chk("swap.b", 32'(bus.b), 32'd7);
    step("pop2", 3'd4, 16'd0, 1'b0);
    chk("pop2.empty", 32'(bus.empty), 32'd1);

    for (int v = 1; v <= DEPTH + 1; v++) step("ovf", 3'd1, WIDTH'(v), 1'b0);
    chk("ovf.full", 32'(bus.full), 32'd1);
    chk("ovf.a", 32'(bus.a), 32'd9);
    for (int k = 0; k < DEPTH - 1; k++) step("drain", 3'd3, 16'd0, 1'b0);
    chk("drain.a", 32'(bus.a), 32'd2);
    step("drain_last", 3'd3, 16'd0, 1'b0);
    chk("drain.empty", 32'(bus.empty), 32'd1);

    step("udf_pop", 3'd3, 16'd0, 1'b0);
    step("udf_pop2", 3'd4, 16'd0, 1'b0);
    step("swap_empty", 3'd5, 16'd0, 1'b0);
    step("pA", 3'd1, 16'hAAAA, 1'b0);
    step("pB", 3'd1, 16'hBBBB, 1'b0);
    step("rsv6", 3'd6, 16'h1234, 1'b0);
    step("rsv7", 3'd7, 16'h5678, 1'b0);
    chk("rsv.a", 32'(bus.a), 32'hBBBB);
    step("rep_short", 3'd3, 16'd0, 1'b0);
    step("rep_one", 3'd2, 16'h0042, 1'b0);

    for (int n = 0; n < 600; n++) begin
      op = 3'($urandom_range(0, 9));
      if ($urandom_range(0, 9) > 7) op = 3'd1;
      wv = WIDTH'($urandom);
      step("rnd", op, wv, ($urandom_range(0, 59) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
